maze_move_sequencer: RTL and testbench

//  Sequences the maze player datapath: synchronises and edge-detects the five buttons, picks one

---
 rtl/maze_pkg.sv | 41 ++++
 rtl/btn_edge_sync.sv | 36 +++
 rtl/maze_move_sequencer.sv | 162 ++++++++++++++++
 tb/tb_maze_move_sequencer.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/maze_pkg.sv
// Shared types and constants for the maze move sequencer: direction codes,
// button bit positions, FSM state encoding and the direction priority picker.
package maze_pkg;

  localparam int POS_W   = 5;
  localparam int HOLD_W  = 20;
  localparam int NUM_BTN = 5;

  // Direction codes presented on q_dir.
  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_RIGHT = 2'd1;
  localparam logic [1:0] DIR_DOWN  = 2'd2;
  localparam logic [1:0] DIR_LEFT  = 2'd3;

  // Bit positions inside the packed button vector {C, L, D, R, U}.
  localparam int BTN_U = 0;
  localparam int BTN_R = 1;
  localparam int BTN_D = 2;
  localparam int BTN_L = 3;
  localparam int BTN_C = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    QUERY = 3'd1,
    WAIT  = 3'd2,
    CHECK = 3'd3,
    HOLD  = 3'd4,
    DONE  = 3'd5
  } state_e;

  // Collapse simultaneous direction edges to one request, U > R > D > L.
  function automatic logic [1:0] pick_dir(input logic [3:0] dir_rise);
    logic [1:0] dir;
    dir = DIR_LEFT;
    if (dir_rise[BTN_D]) dir = DIR_DOWN;
    if (dir_rise[BTN_R]) dir = DIR_RIGHT;
    if (dir_rise[BTN_U]) dir = DIR_UP;
    return dir;
  endfunction

endpackage

// File: rtl/btn_edge_sync.sv
// Brings the raw push buttons into the clock domain with a two-flop
// synchroniser and produces a one-cycle pulse on each synchronised rising edge.
module btn_edge_sync #(
  parameter int N = 5
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [N-1:0] btn_i,
  output logic [N-1:0] level_o,
  output logic [N-1:0] rise_o
);

  logic [N-1:0] meta_q;
  logic [N-1:0] sync_q;
  logic [N-1:0] prev_q;

  // Synchroniser chain plus a delayed copy of the synchronised level.
  always_ff @(posedge clock) begin
    if (reset) begin
      meta_q <= '0;
      sync_q <= '0;
      prev_q <= '0;
    end else begin
      meta_q <= btn_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_edge
    assign rise_o[gi] = sync_q[gi] & ~prev_q[gi];
  end

  assign level_o = sync_q;

endmodule

// File: rtl/maze_move_sequencer.sv
// Player move sequencer: turns button presses into neighbour/wall lookups,
// commits legal moves, checks for the bomb and counts moves.
// Optional feature macro: MOVE_LIMIT_EN (lose once MOVE_LIMIT moves are used).
module maze_move_sequencer
  import maze_pkg::*;
#(
  parameter int GRID_W      = 5,
  parameter int GRID_H      = 5,
  parameter int START_POS   = 0,
  parameter int HOLD_CYCLES = 1000000,
  parameter int MOVE_LIMIT  = 40
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             btnU,
  input  logic             btnR,
  input  logic             btnD,
  input  logic             btnL,
  input  logic             btnC,
  input  logic             maze_ready,
  input  logic [POS_W-1:0] bomb,
  output logic             q_valid,
  output logic [POS_W-1:0] q_pos,
  output logic [1:0]       q_dir,
  input  logic             r_valid,
  input  logic             r_has_nbr,
  input  logic             r_has_wall,
  input  logic [POS_W-1:0] r_nbr_pos,
  output logic [POS_W-1:0] position,
  output logic [7:0]       move_count,
  output logic             bomb_found,
  output logic             game_over,
  output logic             busy
);

`ifdef MOVE_LIMIT_EN
  localparam logic LIMIT_EN = 1'b1;
`else
  localparam logic LIMIT_EN = 1'b0;
`endif

  localparam logic [POS_W-1:0]  START_Q   = POS_W'(START_POS);
  localparam logic [7:0]        LIMIT     = 8'(MOVE_LIMIT);
  localparam logic [POS_W:0]    NUM_SQ    = (POS_W + 1)'(GRID_W * GRID_H);
  // Counter is cleared on the accepting IDLE cycle, so reaching HOLD_CYCLES-1
  // means HOLD_CYCLES cycles have passed since the press was taken.
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = '1;

  logic [NUM_BTN-1:0] btn_level;
  logic [NUM_BTN-1:0] btn_rise;

  btn_edge_sync #(.N(NUM_BTN)) u_btn (
    .clock   (clock),
    .reset   (reset),
    .btn_i   ({btnC, btnL, btnD, btnR, btnU}),
    .level_o (btn_level),
    .rise_o  (btn_rise)
  );

  state_e            state_q, state_d;
  logic [POS_W-1:0]  pos_q, pos_d;
  logic [7:0]        move_cnt_q, move_cnt_d;
  logic              bomb_found_q, bomb_found_d;
  logic              game_over_q, game_over_d;
  logic [1:0]        q_dir_q, q_dir_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;

  logic       commit_ok;
  logic [7:0] move_cnt_inc;

  // A response is only taken as a move when it names a real, unwalled square.
  assign commit_ok    = r_has_nbr && !r_has_wall && ({1'b0, r_nbr_pos} < NUM_SQ);
  assign move_cnt_inc = move_cnt_q + 8'd1;

  // State and datapath registers; reset also abandons any in-flight lookup.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      pos_q        <= START_Q;
      move_cnt_q   <= '0;
      bomb_found_q <= 1'b0;
      game_over_q  <= 1'b0;
      q_dir_q      <= DIR_UP;
      hold_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      pos_q        <= pos_d;
      move_cnt_q   <= move_cnt_d;
      bomb_found_q <= bomb_found_d;
      game_over_q  <= game_over_d;
      q_dir_q      <= q_dir_d;
      hold_cnt_q   <= hold_cnt_d;
    end
  end

  // Next-state and datapath update; edges are only looked at in IDLE.
  always_comb begin
    state_d      = state_q;
    pos_d        = pos_q;
    move_cnt_d   = move_cnt_q;
    bomb_found_d = bomb_found_q;
    game_over_d  = game_over_q;
    q_dir_d      = q_dir_q;

    if (state_q == IDLE)           hold_cnt_d = '0;
    else if (hold_cnt_q != HOLD_MAX) hold_cnt_d = hold_cnt_q + HOLD_W'(1);
    else                           hold_cnt_d = hold_cnt_q;

    case (state_q)
      IDLE: begin
        if (maze_ready) begin
          if (|btn_rise[BTN_L:BTN_U]) begin
            q_dir_d = pick_dir(btn_rise[BTN_L:BTN_U]);
            state_d = QUERY;
          end else if (btn_rise[BTN_C]) begin
            state_d = CHECK;
          end
        end
      end
      QUERY: state_d = WAIT;
      WAIT: begin
        if (r_valid) begin
          state_d = HOLD;
          if (commit_ok) begin
            pos_d = r_nbr_pos;
            if (move_cnt_q != 8'hFF) begin
              move_cnt_d = move_cnt_inc;
              if (LIMIT_EN && (move_cnt_inc == LIMIT) && !bomb_found_q) begin
                game_over_d = 1'b1;
                state_d     = DONE;
              end
            end
          end
        end
      end
      CHECK: begin
        if (pos_q == bomb) begin
          bomb_found_d = 1'b1;
          state_d      = DONE;
        end else begin
          state_d = HOLD;
        end
      end
      HOLD: begin
        if ((hold_cnt_q >= HOLD_LAST) && !(|btn_level)) state_d = IDLE;
      end
      DONE:    state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  assign q_valid    = (state_q == QUERY);
  assign q_pos      = pos_q;
  assign q_dir      = q_dir_q;
  assign position   = pos_q;
  assign move_count = move_cnt_q;
  assign bomb_found = bomb_found_q;
  assign game_over  = game_over_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_maze_move_sequencer.sv
// Bench for maze_move_sequencer: scenario tasks plus a randomized walk checked
// against a grid-coordinate game model. Build with MOVE_LIMIT_EN to cover the
// move-limit variant.
module tb_maze_move_sequencer;

  localparam int W = 5;
  localparam int H = 5;
  localparam int HOLD = 16;
  localparam int LIMIT = 3;
`ifdef MOVE_LIMIT_EN
  localparam bit LIMIT_EN = 1'b1;
`else
  localparam bit LIMIT_EN = 1'b0;
`endif

  logic clock;
  logic reset;
  logic btnU, btnR, btnD, btnL, btnC;
  logic maze_ready;
  logic [4:0] bomb;
  logic q_valid;
  logic [4:0] q_pos;
  logic [1:0] q_dir;
  logic r_valid, r_has_nbr, r_has_wall;
  logic [4:0] r_nbr_pos;
  logic [4:0] position;
  logic [7:0] move_count;
  logic bomb_found, game_over, busy;

  maze_move_sequencer #(
    .GRID_W(W), .GRID_H(H), .START_POS(0), .HOLD_CYCLES(HOLD), .MOVE_LIMIT(LIMIT)
  ) dut (
    .clock(clock), .reset(reset),
    .btnU(btnU), .btnR(btnR), .btnD(btnD), .btnL(btnL), .btnC(btnC),
    .maze_ready(maze_ready), .bomb(bomb),
    .q_valid(q_valid), .q_pos(q_pos), .q_dir(q_dir),
    .r_valid(r_valid), .r_has_nbr(r_has_nbr), .r_has_wall(r_has_wall), .r_nbr_pos(r_nbr_pos),
    .position(position), .move_count(move_count),
    .bomb_found(bomb_found), .game_over(game_over), .busy(busy)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int n_cmp = 0;
  int n_err = 0;

  // Lookup environment state (written only by the responder).
  int nq = 0;
  int stable_err = 0;
  int stray_seen = 0;
  logic [1:0] last_dir = 2'd0;
  logic [4:0] last_pos = 5'd0;

  // Environment controls (written only by the main sequence).
  bit resp_en = 1'b1;
  int max_lat = 1;
  int stray_cnt = 0;
  bit walls [25][4];

  // Game model in grid coordinates.
  int m_pos, m_cnt;
  bit m_bomb, m_over, m_done;

  // Lookup responder: answers every query after 1..max_lat cycles and can inject a stray strobe.
  initial begin : responder
    int lat;
    int p;
    int d;
    r_valid = 1'b0; r_has_nbr = 1'b0; r_has_wall = 1'b0; r_nbr_pos = 5'd0;
    forever begin
      @(negedge clock);
      if (stray_seen != stray_cnt) begin
        stray_seen = stray_cnt;
        r_has_nbr = 1'b1; r_has_wall = 1'b0; r_nbr_pos = 5'd7; r_valid = 1'b1;
        @(negedge clock);
        r_valid = 1'b0;
      end else if (q_valid === 1'b1) begin
        nq++;
        last_dir = q_dir;
        last_pos = q_pos;
        if (resp_en) begin
          lat = $urandom_range(max_lat, 1);
          for (int k = 1; k < lat; k++) begin
            @(negedge clock);
            if (q_pos !== last_pos || q_dir !== last_dir) stable_err++;
          end
          @(negedge clock);
          if (q_pos !== last_pos || q_dir !== last_dir) stable_err++;
          p = int'(last_pos);
          d = int'(last_dir);
          r_has_wall = (p < 25) ? walls[p][d] : 1'b0;
          case (d)
            0:       begin r_has_nbr = (p >= W);           r_nbr_pos = 5'(p - W); end
            1:       begin r_has_nbr = ((p % W) != W - 1); r_nbr_pos = 5'(p + 1); end
            2:       begin r_has_nbr = (p < W * (H - 1));  r_nbr_pos = 5'(p + W); end
            default: begin r_has_nbr = ((p % W) != 0);     r_nbr_pos = 5'(p - 1); end
          endcase
          if (!r_has_nbr) r_nbr_pos = 5'($urandom_range(31, 0));
          r_valid = 1'b1;
          @(negedge clock);
          r_valid = 1'b0;
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got hang required finish");
    $fatal(1, "watchdog");
  end

  task automatic clear_walls;
    for (int s = 0; s < 25; s++)
      for (int d = 0; d < 4; d++) walls[s][d] = 1'b0;
  endtask

  task automatic do_reset;
    @(negedge clock);
    reset = 1'b1;
    {btnC, btnL, btnD, btnR, btnU} = 5'b0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    m_pos = 0; m_cnt = 0; m_bomb = 0; m_over = 0; m_done = 0;
    @(negedge clock);
  endtask

  // One button press, checked against the game model.
  task automatic press(input logic [4:0] mask, input string tag);
    int nq0, x, y, nx, ny, t, pre_pos;
    bit exp_q, ok;
    logic [1:0] exp_dir;
    nq0 = nq; exp_q = 0; exp_dir = 2'd0; pre_pos = m_pos;
    if (!m_done && maze_ready) begin
      if (mask[3:0] != 4'b0) begin
        exp_q = 1;
        if (mask[0]) exp_dir = 2'd0;
        else if (mask[1]) exp_dir = 2'd1;
        else if (mask[2]) exp_dir = 2'd2;
        else exp_dir = 2'd3;
        x = m_pos % W; y = m_pos / W; nx = x; ny = y;
        case (exp_dir)
          2'd0:    ny = y - 1;
          2'd1:    nx = x + 1;
          2'd2:    ny = y + 1;
          default: nx = x - 1;
        endcase
        ok = (nx >= 0) && (nx < W) && (ny >= 0) && (ny < H) && !walls[m_pos][exp_dir];
        if (ok) begin
          m_pos = ny * W + nx;
          if (m_cnt < 255) begin
            m_cnt++;
            if (LIMIT_EN && m_cnt == LIMIT && !m_bomb) begin m_over = 1; m_done = 1; end
          end
        end
      end else if (mask[4] && m_pos == int'(bomb)) begin
        m_bomb = 1; m_done = 1;
      end
    end
    @(negedge clock);
    {btnC, btnL, btnD, btnR, btnU} = mask;
    repeat (6) @(negedge clock);
    {btnC, btnL, btnD, btnR, btnU} = 5'b0;
    if (m_done) repeat (30) @(negedge clock);
    else begin
      t = 0;
      while (busy !== 1'b0 && t < 400) begin @(negedge clock); t++; end
    end
    n_cmp++; if ((nq - nq0) != int'(exp_q)) begin n_err++; $display("FAIL %s queries: got %0d required %0d", tag, nq - nq0, exp_q); end
    if (exp_q) begin
      n_cmp++; if (last_dir !== exp_dir) begin n_err++; $display("FAIL %s q_dir: got %0d required %0d", tag, last_dir, exp_dir); end
      n_cmp++; if (last_pos !== 5'(pre_pos)) begin n_err++; $display("FAIL %s q_pos: got %0d required %0d", tag, last_pos, pre_pos); end
    end
    n_cmp++; if (position !== 5'(m_pos)) begin n_err++; $display("FAIL %s position: got %0d required %0d", tag, position, m_pos); end
    n_cmp++; if (move_count !== 8'(m_cnt)) begin n_err++; $display("FAIL %s move_count: got %0d required %0d", tag, move_count, m_cnt); end
    n_cmp++; if (bomb_found !== m_bomb) begin n_err++; $display("FAIL %s bomb_found: got %b required %b", tag, bomb_found, m_bomb); end
    n_cmp++; if (game_over !== m_over) begin n_err++; $display("FAIL %s game_over: got %b required %b", tag, game_over, m_over); end
    n_cmp++; if (busy !== m_done) begin n_err++; $display("FAIL %s busy: got %b required %b", tag, busy, m_done); end
    $display("press %s mask=%b pos=%0d cnt=%0d bomb=%b over=%b", tag, mask, position, move_count, bomb_found, game_over);
  endtask

  task automatic check_reset_values(input string tag);
    n_cmp++; if (position !== 5'd0) begin n_err++; $display("FAIL %s position: got %0d required 0", tag, position); end
    n_cmp++; if (move_count !== 8'd0) begin n_err++; $display("FAIL %s move_count: got %0d required 0", tag, move_count); end
    n_cmp++; if (bomb_found !== 1'b0) begin n_err++; $display("FAIL %s bomb_found: got %b required 0", tag, bomb_found); end
    n_cmp++; if (game_over !== 1'b0) begin n_err++; $display("FAIL %s game_over: got %b required 0", tag, game_over); end
    n_cmp++; if (q_valid !== 1'b0) begin n_err++; $display("FAIL %s q_valid: got %b required 0", tag, q_valid); end
    n_cmp++; if (q_dir !== 2'd0) begin n_err++; $display("FAIL %s q_dir: got %0d required 0", tag, q_dir); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL %s busy: got %b required 0", tag, busy); end
    $display("reset %s pos=%0d cnt=%0d busy=%b", tag, position, move_count, busy);
  endtask

  task automatic test_reset;
    clear_walls(); max_lat = 1;
    do_reset();
    check_reset_values("reset_initial");
    press(5'b00100, "reset_D");
    press(5'b00010, "reset_R");
    do_reset();
    check_reset_values("reset_after_moves");
  endtask

  task automatic test_latency;
    clear_walls(); max_lat = 1;
    do_reset();
    @(negedge clock);
    btnR = 1'b1;
    repeat (3) @(negedge clock);
    n_cmp++; if (q_valid !== 1'b1) begin n_err++; $display("FAIL lat q_valid: got %b required 1", q_valid); end
    n_cmp++; if (q_dir !== 2'd1) begin n_err++; $display("FAIL lat q_dir: got %0d required 1", q_dir); end
    @(negedge clock);
    n_cmp++; if (q_valid !== 1'b0) begin n_err++; $display("FAIL lat q_valid_pulse: got %b required 0", q_valid); end
    n_cmp++; if (position !== 5'd0) begin n_err++; $display("FAIL lat early_position: got %0d required 0", position); end
    @(negedge clock);
    n_cmp++; if (position !== 5'd1) begin n_err++; $display("FAIL lat position: got %0d required 1", position); end
    n_cmp++; if (move_count !== 8'd1) begin n_err++; $display("FAIL lat move_count: got %0d required 1", move_count); end
    btnR = 1'b0;
    $display("latency pos=%0d cnt=%0d", position, move_count);
    repeat (3 * HOLD) @(negedge clock);
  endtask

  task automatic test_blocked;
    int nq0, t;
    clear_walls(); max_lat = 1;
    do_reset();
    nq0 = nq;
    @(negedge clock);
    btnU = 1'b1;
    repeat (10) @(negedge clock);
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL blocked busy_early: got %b required 1", busy); end
    repeat (3 * HOLD) @(negedge clock);
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL blocked busy_held: got %b required 1", busy); end
    btnU = 1'b0;
    t = 0;
    while (busy !== 1'b0 && t < 50) begin @(negedge clock); t++; end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL blocked idle: got %b required 0", busy); end
    n_cmp++; if (position !== 5'd0) begin n_err++; $display("FAIL blocked position: got %0d required 0", position); end
    n_cmp++; if (move_count !== 8'd0) begin n_err++; $display("FAIL blocked move_count: got %0d required 0", move_count); end
    n_cmp++; if ((nq - nq0) != 1) begin n_err++; $display("FAIL blocked queries: got %0d required 1", nq - nq0); end
    $display("blocked pos=%0d cnt=%0d queries=%0d", position, move_count, nq - nq0);
  endtask

  task automatic test_priority;
    int nq1;
    clear_walls(); max_lat = 1;
    do_reset();
    press(5'b00010, "prio_R");
    press(5'b00100, "prio_D");
    press(5'b01001, "prio_U+L");
    nq1 = nq;
    repeat (3 * HOLD) @(negedge clock);
    n_cmp++; if (nq != nq1) begin n_err++; $display("FAIL prio replay: got %0d queries required %0d", nq, nq1); end
    n_cmp++; if (position !== 5'(m_pos)) begin n_err++; $display("FAIL prio final_pos: got %0d required %0d", position, m_pos); end
    $display("priority pos=%0d queries=%0d", position, nq);
  endtask

  task automatic test_dropped_edges;
    int nq0, t;
    clear_walls(); max_lat = 1;
    do_reset();
    nq0 = nq;
    @(negedge clock);
    btnR = 1'b1;
    repeat (6) @(negedge clock);
    btnR = 1'b0;
    repeat (2) @(negedge clock);
    btnD = 1'b1;
    repeat (2) @(negedge clock);
    btnD = 1'b0;
    t = 0;
    while (busy !== 1'b0 && t < 100) begin @(negedge clock); t++; end
    repeat (40) @(negedge clock);
    n_cmp++; if ((nq - nq0) != 1) begin n_err++; $display("FAIL dropped queries: got %0d required 1", nq - nq0); end
    n_cmp++; if (position !== 5'd1) begin n_err++; $display("FAIL dropped position: got %0d required 1", position); end
    n_cmp++; if (move_count !== 8'd1) begin n_err++; $display("FAIL dropped move_count: got %0d required 1", move_count); end
    m_pos = 1; m_cnt = 1;
    $display("dropped pos=%0d cnt=%0d queries=%0d", position, move_count, nq - nq0);
  endtask

  task automatic test_not_ready;
    int nq0;
    clear_walls(); max_lat = 1;
    do_reset();
    maze_ready = 1'b0;
    press(5'b00010, "notready_R");
    maze_ready = 1'b1;
    nq0 = nq;
    repeat (10) @(negedge clock);
    n_cmp++; if (nq != nq0) begin n_err++; $display("FAIL notready replay: got %0d queries required %0d", nq, nq0); end
    press(5'b00010, "ready_R");
  endtask

  task automatic test_bomb;
    clear_walls(); max_lat = 1;
    do_reset();
    bomb = 5'd6;
    press(5'b00010, "bomb_R");
    press(5'b10000, "bomb_C_miss");
    press(5'b00100, "bomb_D");
    press(5'b10000, "bomb_C_hit");
    press(5'b00010, "bomb_after_R");
    press(5'b10000, "bomb_after_C");
  endtask

  task automatic test_reset_mid_query;
    int t;
    clear_walls(); max_lat = 1;
    do_reset();
    resp_en = 1'b0;
    @(negedge clock);
    btnR = 1'b1;
    t = 0;
    while (q_valid !== 1'b1 && t < 10) begin @(negedge clock); t++; end
    n_cmp++; if (q_valid !== 1'b1) begin n_err++; $display("FAIL midq q_valid: got %b required 1", q_valid); end
    @(negedge clock);
    reset = 1'b1;
    btnR = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    stray_cnt++;
    repeat (4) @(negedge clock);
    n_cmp++; if (position !== 5'd0) begin n_err++; $display("FAIL midq position: got %0d required 0", position); end
    n_cmp++; if (move_count !== 8'd0) begin n_err++; $display("FAIL midq move_count: got %0d required 0", move_count); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL midq busy: got %b required 0", busy); end
    $display("reset_mid_query pos=%0d cnt=%0d busy=%b", position, move_count, busy);
    resp_en = 1'b1;
  endtask

  task automatic test_random;
    int r;
    logic [4:0] mask;
    do_reset();
    bomb = 5'($urandom_range(24, 0));
    for (int s = 0; s < 25; s++)
      for (int d = 0; d < 4; d++) walls[s][d] = ($urandom_range(3, 0) == 0);
    max_lat = 3;
    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(5, 0);
      case (r)
        0: mask = 5'b00001;
        1: mask = 5'b00010;
        2: mask = 5'b00100;
        3: mask = 5'b01000;
        4: mask = 5'b10000;
        default: mask = 5'($urandom_range(31, 1));
      endcase
      press(mask, "random");
    end
    n_cmp++; if (stable_err != 0) begin n_err++; $display("FAIL random q_stable: got %0d changes required 0", stable_err); end
    clear_walls();
    max_lat = 1;
    bomb = 5'd24;
  endtask

`ifdef MOVE_LIMIT_EN
  task automatic test_move_limit;
    clear_walls(); max_lat = 1;
    do_reset();
    bomb = 5'd24;
    press(5'b00001, "limit_U_blocked");
    press(5'b00010, "limit_R1");
    press(5'b00010, "limit_R2");
    press(5'b00010, "limit_R3");
    press(5'b00100, "limit_D_after");
  endtask
`else
  task automatic test_saturation;
    clear_walls(); max_lat = 1;
    do_reset();
    bomb = 5'd24;
    for (int i = 0; i < 258; i++) press((i % 2 == 0) ? 5'b00010 : 5'b01000, "sat");
  endtask
`endif

  initial begin : main
    reset = 1'b1;
    {btnC, btnL, btnD, btnR, btnU} = 5'b0;
    maze_ready = 1'b1;
    bomb = 5'd24;
    clear_walls();
    test_reset();
    test_latency();
    test_blocked();
    test_priority();
    test_dropped_edges();
    test_not_ready();
    test_bomb();
    test_reset_mid_query();
    test_random();
`ifdef MOVE_LIMIT_EN
    test_move_limit();
`else
    test_saturation();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
